wide_add_seq: RTL
=================

WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: number of 4-bit slices; operand width W = 4*NIBBLES; legal range 2..16.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-004 SHALL have port start, input, 1: request a new addition; sampled only in IDLE.
REQ-005 SHALL have port clr, input, 1: synchronous abort; returns the block to IDLE.
REQ-006 SHALL have port a, input, W: first operand.
REQ-007 SHALL have port b, input, W: second operand.
REQ-008 SHALL have port cin, input, 1: carry into slice 0.
REQ-009 SHALL have port busy, output, 1: high in RUN and DONE.
REQ-010 SHALL have port done, output, 1: one-cycle result-valid pulse.
REQ-011 SHALL have port sum, output, W: registered result.
REQ-012 SHALL have port cout, output, 1: carry out of the top slice.
REQ-013 SHALL have port ovf, output, 1: two's-complement overflow of the W-bit sum.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN and DONE; busy = (state != IDLE).
REQ-015 SHALL, in IDLE with start=1 and clr=0: latch a, b and cin, clear the slice index to 0, and enter RUN.
REQ-016 SHALL, in each RUN cycle, add slice idx of the latched a and b plus the carry register through one 4-bit ripple adder; write sum[4*idx+3:4*idx]; update the carry register; increment idx.
REQ-017 SHALL enter DONE on the edge that processes slice NIBBLES-1; this gives exactly NIBBLES edges from start acceptance to done=1.
REQ-018 SHALL assert done for exactly one cycle in DONE, then return to IDLE unconditionally.
REQ-019 SHALL set cout to the final carry register value, and ovf to (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]), using latched operands; both update on the DONE-entry edge.
REQ-020 SHALL hold sum, cout and ovf stable from DONE until the next accepted start; partial sums are visible during RUN.
REQ-021 SHALL ignore start while busy=1; a start in the DONE cycle is also ignored.
REQ-022 SHALL give clr priority over start: in any state, clr=1 forces IDLE, zeroes the carry register, drives done=0 and leaves sum, cout and ovf unchanged.
REQ-023 SHALL make input changes on a, b and cin after acceptance have no effect on the result in progress.

Reset
REQ-024 SHALL, on rst_n=0, immediately force state=IDLE, idx=0, carry=0, sum=0, cout=0, ovf=0, done=0 and busy=0, including mid-operation.
REQ-025 SHALL, on rst_n deassertion, accept start no earlier than the first rising clk edge.

Structure
REQ-026 SHALL take the state encoding (IDLE/RUN/DONE) and the slice width constant (4) from the shared package wide_add_pkg.
REQ-027 SHALL instantiate exactly one sub-module, add4_slice: a combinational 4-bit ripple adder built from four full-adder cells; no other arithmetic in the top level.
REQ-028 SHALL size idx to $clog2(NIBBLES) bits and SHALL NOT let it wrap within RUN.

Verification (NIBBLES=4)
REQ-029 SHALL cover: a=0x1234, b=0x0FFF, cin=0 -> after 4 edges done=1, sum=0x2233, cout=0, ovf=0.
REQ-030 SHALL cover: a=0xFFFF, b=0x0001, cin=0 -> carry ripples through all slices; sum=0x0000, cout=1, ovf=0.
REQ-031 SHALL cover: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; a=0x0000, b=0x0000, cin=1 -> sum=0x0001.
REQ-032 SHALL cover: second start pulsed in RUN and in DONE -> ignored, exactly one done pulse; a new start in the following IDLE cycle -> accepted.
REQ-033 SHALL cover: rst_n=0 after the 2nd RUN edge -> all outputs 0 immediately with no clk edge; the next start computes correctly.
REQ-034 SHALL cover: clr=1 together with start in IDLE -> stays IDLE; clr in RUN -> IDLE, no done pulse, sum retains the partial value.

Source files
------------

// File: rtl/wide_add_pkg.sv
// Shared constants and FSM state encoding for the sequential wide adder.
package wide_add_pkg;

    // Width of one adder slice in bits.
    localparam int unsigned SLICE_W = 4;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add4_slice.sv
// Combinational 4-bit ripple-carry adder built from four full-adder cells.
module add4_slice
    import wide_add_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               c_i,
    output logic [SLICE_W-1:0] s_o,
    output logic               c_o
);

    logic [SLICE_W:0] carry;

    assign carry[0] = c_i;

    // One full-adder cell per bit; carry ripples upward.
    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_o = carry[SLICE_W];

endmodule

// File: rtl/wide_add_seq.sv
// Sequential W-bit adder: processes one 4-bit slice per clock through a
// single shared ripple slice, pulsing done when the full sum is ready.
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       clr,
    input  logic [SLICE_W*NIBBLES-1:0] a,
    input  logic [SLICE_W*NIBBLES-1:0] b,
    input  logic                       cin,
    output logic                       busy,
    output logic                       done,
    output logic [SLICE_W*NIBBLES-1:0] sum,
    output logic                       cout,
    output logic                       ovf
);

    localparam int unsigned W     = SLICE_W * NIBBLES;
    localparam int unsigned IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_c;

    assign slice_a = a_q[idx_q * SLICE_W +: SLICE_W];
    assign slice_b = b_q[idx_q * SLICE_W +: SLICE_W];

    add4_slice u_slice (
        .a_i (slice_a),
        .b_i (slice_b),
        .c_i (carry_q),
        .s_o (slice_s),
        .c_o (slice_c)
    );

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath control; clr overrides everything else.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done    = 1'b0;

        if (clr) begin
            state_d = ST_IDLE;
            carry_d = 1'b0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_d     = a;
                        b_d     = b;
                        carry_d = cin;
                        idx_d   = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_d[idx_q * SLICE_W +: SLICE_W] = slice_s;
                    carry_d = slice_c;
                    if (idx_q == LAST_IDX) begin
                        // Top slice: its sum MSB is the result sign bit.
                        state_d = ST_DONE;
                        cout_d  = slice_c;
                        ovf_d   = (a_q[W-1] == b_q[W-1]) &&
                                  (slice_s[SLICE_W-1] != a_q[W-1]);
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
